// File: rtl/fifo_stream_reader.sv
// Read-side adapter from a synchronous FIFO (one-cycle read latency) to a valid/ready stream.
// A 2-entry skid buffer absorbs the latency so the consumer can take one word per clock.
module fifo_stream_reader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       buf_cnt
);

    logic [WIDTH-1:0] buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             inflight;
    logic             pop;
    logic [2:0]       credit;

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf_mem[rd_ptr];

    // A read is only issued when the word it returns is guaranteed a free slot.
    always_comb begin
        pop     = m_valid & m_ready;
        credit  = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd = !fifo_empty && !flush && (credit < 3'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            inflight   <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            inflight <= fifo_rd;
            if (flush) begin
                // Realign both pointers so the emptied buffer restarts from slot 0.
                wr_ptr  <= 1'b0;
                rd_ptr  <= 1'b0;
                buf_cnt <= 2'd0;
            end else begin
                if (inflight) begin
                    buf_mem[wr_ptr] <= fifo_dout;
                    wr_ptr          <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized checks of fifo_stream_reader against a behavioral FIFO and a reference queue.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd;
    logic [31:0] fifo_dout = '0;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [1:0]  buf_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] fq[$];
    logic [31:0] exp_q[$];

    fifo_stream_reader #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .buf_cnt    (buf_cnt)
    );

    always #5 clk = ~clk;

    // Behavioral synchronous FIFO: dout valid the cycle after rd, registered empty flag.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd && fq.size() != 0)
                fifo_dout <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] v);
        fq.push_back(v);
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            smp();
            if (m_valid && m_ready)
                chk("drain_data", m_data, exp_q.pop_front());
            nxt();
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic wait_full(input string tag);
        for (int i = 0; i < 10; i++) begin
            smp();
            if (buf_cnt == 2'd2) break;
            nxt();
        end
        chk(tag, {30'd0, buf_cnt}, 32'd2);
    endtask

    initial begin
        int rdcnt;
        int viol;
        logic [31:0] v;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_buf_cnt", {30'd0, buf_cnt}, 32'd0);
        rst_n = 1'b1;
        nxt();

        // Single word
        m_ready = 1'b1;
        push(32'hDEADBEEF);
        smp(); chk("single_rd_c0", {31'd0, fifo_rd}, 32'd0); nxt();
        smp(); chk("single_rd_c1", {31'd0, fifo_rd}, 32'd1); nxt();
        smp(); chk("single_rd_c2", {31'd0, fifo_rd}, 32'd0);
               chk("single_valid_c2", {31'd0, m_valid}, 32'd0); nxt();
        smp(); chk("single_valid_c3", {31'd0, m_valid}, 32'd1);
               chk("single_data_c3", m_data, 32'hDEADBEEF);
               chk("single_cnt_c3", {30'd0, buf_cnt}, 32'd1); nxt();
        smp(); chk("single_valid_c4", {31'd0, m_valid}, 32'd0);
               chk("single_cnt_c4", {30'd0, buf_cnt}, 32'd0); nxt();

        // Streaming 8 words, no bubbles
        for (int i = 0; i < 8; i++) push(i);
        for (int c = 0; c < 12; c++) begin
            smp();
            chk("stream_rd", {31'd0, fifo_rd}, {31'd0, (c >= 1 && c <= 8)});
            chk("stream_valid", {31'd0, m_valid}, {31'd0, (c >= 3 && c <= 10)});
            if (c >= 3 && c <= 10)
                chk("stream_data", m_data, c - 3);
            nxt();
        end

        // Backpressure
        m_ready = 1'b0;
        rdcnt = 0;
        for (int i = 0; i < 5; i++) push(32'h100 + i);
        for (int c = 0; c < 10; c++) begin
            smp();
            if (fifo_rd) rdcnt++;
            if (c >= 3) begin
                chk("bp_hold_data", m_data, 32'h100);
                chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
            end
            nxt();
        end
        chk("bp_rd_pulses", rdcnt, 32'd2);
        chk("bp_buf_cnt", {30'd0, buf_cnt}, 32'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h100 + i);
        drain(20);

        // Flush with a full buffer
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h200 + i);
        wait_full("flush_fill");
        nxt();
        flush = 1'b1;
        smp(); chk("flush_rd_low", {31'd0, fifo_rd}, 32'd0); nxt();
        flush = 1'b0;
        m_ready = 1'b1;
        smp(); chk("flush_cnt", {30'd0, buf_cnt}, 32'd0);
               chk("flush_valid", {31'd0, m_valid}, 32'd0); nxt();
        exp_q.push_back(32'h202);
        exp_q.push_back(32'h203);
        drain(15);

        // Flush with a word in flight: that word is lost
        push(32'h300);
        push(32'h301);
        nxt();
        nxt();
        flush = 1'b1;
        smp(); chk("flushif_rd_low", {31'd0, fifo_rd}, 32'd0); nxt();
        flush = 1'b0;
        smp(); chk("flushif_cnt", {30'd0, buf_cnt}, 32'd0);
               chk("flushif_valid", {31'd0, m_valid}, 32'd0); nxt();
        exp_q.push_back(32'h301);
        drain(15);

        // Random traffic with scoreboard and empty guard
        viol = 0;
        for (int n = 0; n < 50000; n++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && fq.size() < 15) begin
                v = $urandom;
                push(v);
                exp_q.push_back(v);
            end
            smp();
            if (fifo_rd && fifo_empty) viol++;
            if (m_valid && m_ready) begin
                if (exp_q.size() != 0) begin
                    chk("rand_data", m_data, exp_q.pop_front());
                end else begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL rand_extra: observed %0h expected none", m_data);
                end
            end
            nxt();
        end
        chk("empty_guard", viol, 32'd0);
        m_ready = 1'b1;
        drain(100);

        // Asynchronous reset mid-stream
        m_ready = 1'b0;
        push(32'h400);
        push(32'h401);
        push(32'h402);
        wait_full("arst_fill");
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_rd", {31'd0, fifo_rd}, 32'd0);
        chk("arst_cnt", {30'd0, buf_cnt}, 32'd0);
        chk("arst_data", m_data, 32'd0);
        nxt();
        rst_n = 1'b1;
        exp_q.delete();
        push(32'hCAFE);
        m_ready = 1'b1;
        exp_q.push_back(32'hCAFE);
        drain(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side adapter between a sync_fifo_spram/sync_fifo_tpram instance and a valid/ready streaming consumer. It drives the FIFO rd strobe and absorbs the FIFO's one-cycle read latency (dout valid the cycle after rd) in a 2-entry output buffer. The consumer side gets a registered valid/ready stream at full throughput of one word per clock. It sits directly on the FIFO's rd/dout/empty pins.

Parameters:
WIDTH, 32, data word width; must match the attached FIFO's WIDTH.

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  reset, asynchronous and active-low.
fifo_empty  input  1  FIFO empty flag.
fifo_rd  output  1  FIFO read strobe; one word popped per cycle high.
fifo_dout  input  WIDTH  FIFO read data, valid the cycle after fifo_rd.
flush  input  1  synchronous discard of buffered and in-flight words.
m_valid  output  1  output word available.
m_ready  input  1  consumer accepts the word.
m_data  output  WIDTH  output word (head of buffer).
buf_cnt  output  2  words held in the output buffer (0..2).

Behaviour:
- Reset (rst_n=0, async): fifo_rd=0, m_valid=0, m_data=0, buf_cnt=0, in-flight flag=0, buffer pointers=0.
- Internal state: 2-entry buffer with 1-bit wr_ptr/rd_ptr; buf_cnt; inflight register, set to fifo_rd registered each cycle.
- pop = m_valid & m_ready.
- fifo_rd is combinational: !fifo_empty & !flush & (buf_cnt + inflight - pop) < 2. It is never high while fifo_empty=1.
- Capture: when inflight=1 and flush=0, fifo_dout is written at wr_ptr on that edge; wr_ptr toggles.
- buf_cnt_next = buf_cnt + (inflight & !flush) - pop, except that flush forces 0.
- m_valid = (buf_cnt != 0). m_data = buf[rd_ptr]. rd_ptr toggles on pop.
- Latency: fifo_rd high in cycle N -> word in buffer at edge ending N+1 -> m_valid high in cycle N+2. First word reaches the output 2 cycles after the rd issue.
- Throughput: in steady state (buf_cnt=1, inflight=1, m_ready=1), fifo_rd stays high every cycle, giving 1 word/clk with no bubbles.
- Backpressure: m_valid & !m_ready holds m_data and m_valid stable. At most 2 words are ever buffered. The credit rule guarantees no overflow: a word in flight always has a free slot.
- Simultaneous capture and pop in the same cycle: buf_cnt is unchanged and both pointers advance.
- flush=1 (one cycle): fifo_rd=0 in that cycle, and the buffer plus any in-flight word are discarded (that word is consumed from the FIFO and lost). m_valid=0 from the next cycle. pop in the flush cycle is still a valid handshake. Normal operation resumes the cycle after.
- Reset mid-operation clears all state immediately. The FIFO is reset by the same rst_n, so no stale in-flight word survives.
- Word order at m_data equals FIFO write order. There is no duplication or loss except through flush.
- Pointer wrap: 1-bit pointers wrap naturally at 2.

Test Plan:
- Single word: write 0xDEADBEEF to the FIFO, m_ready=1 -> fifo_rd pulses once; m_valid high for exactly 1 cycle, 2 cycles after the rd, with m_data=0xDEADBEEF; buf_cnt returns to 0.
- Streaming: preload 8 words 0..7, m_ready=1 -> fifo_rd high 8 consecutive cycles; m_data=0..7 on 8 consecutive cycles, no bubbles.
- Backpressure: preload 5 words, m_ready=0 for 10 cycles -> exactly 2 fifo_rd pulses, buf_cnt=2, m_data=word0 held stable. Then m_ready=1 -> words 0..4 delivered in order.
- Flush in flight: preload 4 words, m_ready=0 until buf_cnt=2, assert flush 1 cycle -> buf_cnt=0 and m_valid=0 next cycle. Reads resume and deliver the remaining words in order. Flushed words never appear.
- Empty guard: random wr/rd with FIFO depth 15 and random m_ready over 50000 cycles -> fifo_rd never high with fifo_empty=1; output sequence matches the reference queue of writes (scoreboard).
- Async reset mid-stream: assert rst_n low between clock edges with buf_cnt=2 -> m_valid, fifo_rd and buf_cnt are 0 immediately, before the next edge. After release, a new word arrives correctly.
